// File: rtl/phase_timer_if.sv
// rtl/phase_timer_if.sv - operation/timing bundle between wash controller and phase_timer
interface phase_timer_if #(
    parameter int CNT_W = 16
);
    logic             fill_Water_Operation;
    logic             heat_Water_Operation;
    logic             wash_Operation;
    logic             rinse_Operation;
    logic             spin_Operation;
    logic             sig_Lid_Closed;
    logic             sig_Time_Out;
    logic             sig_Wash_Completed;
    logic             sig_Rinse_Completed;
    logic             sig_Spin_Completed;
    logic [CNT_W-1:0] remaining_Time;
    logic [2:0]       phase;

    modport master (
        output fill_Water_Operation, heat_Water_Operation, wash_Operation,
               rinse_Operation, spin_Operation, sig_Lid_Closed,
        input  sig_Time_Out, sig_Wash_Completed, sig_Rinse_Completed,
               sig_Spin_Completed, remaining_Time, phase
    );

    modport slave (
        input  fill_Water_Operation, heat_Water_Operation, wash_Operation,
               rinse_Operation, spin_Operation, sig_Lid_Closed,
        output sig_Time_Out, sig_Wash_Completed, sig_Rinse_Completed,
               sig_Spin_Completed, remaining_Time, phase
    );
endinterface

// File: rtl/phase_timer.sv
// rtl/phase_timer.sv - per-phase prescaled down-counter producing wash controller timing flags
// Optional lid pause in wash/rinse/spin enabled by defining PAUSE_ON_LID_EN.
module phase_timer #(
    parameter int CLK_DIV      = 4,
    parameter int CNT_W        = 16,
    parameter int FILL_TIMEOUT = 20,
    parameter int HEAT_TIMEOUT = 30,
    parameter int WASH_TIME    = 12,
    parameter int RINSE_TIME   = 8,
    parameter int SPIN_TIME    = 6
) (
    input  logic         clock,
    input  logic         reset_n,
    phase_timer_if.slave bus
);
    localparam int PW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    typedef enum logic [2:0] {
        P_IDLE  = 3'd0,
        P_FILL  = 3'd1,
        P_HEAT  = 3'd2,
        P_WASH  = 3'd3,
        P_RINSE = 3'd4,
        P_SPIN  = 3'd5
    } phase_t;

    phase_t           phase_q, phase_d, req;
    logic [PW-1:0]    presc_q, presc_d;
    logic [CNT_W-1:0] rem_q, rem_d;
    logic             to_q, wc_q, rc_q, sc_q;
    logic             to_d, wc_d, rc_d, sc_d;
    logic             paused;
    logic             done;

    function automatic logic [CNT_W-1:0] dur_of(input phase_t p);
        case (p)
            P_FILL:  dur_of = CNT_W'(FILL_TIMEOUT);
            P_HEAT:  dur_of = CNT_W'(HEAT_TIMEOUT);
            P_WASH:  dur_of = CNT_W'(WASH_TIME);
            P_RINSE: dur_of = CNT_W'(RINSE_TIME);
            P_SPIN:  dur_of = CNT_W'(SPIN_TIME);
            default: dur_of = '0;
        endcase
    endfunction

    // Overlapping operation requests resolve by priority, spin highest.
    always_comb begin
        if (bus.spin_Operation)            req = P_SPIN;
        else if (bus.rinse_Operation)      req = P_RINSE;
        else if (bus.wash_Operation)       req = P_WASH;
        else if (bus.heat_Water_Operation) req = P_HEAT;
        else if (bus.fill_Water_Operation) req = P_FILL;
        else                               req = P_IDLE;
    end

`ifdef PAUSE_ON_LID_EN
    always_comb begin
        paused = ((phase_q == P_WASH) || (phase_q == P_RINSE) || (phase_q == P_SPIN))
                 && !bus.sig_Lid_Closed;
    end
`else
    logic unused_lid;
    assign unused_lid = bus.sig_Lid_Closed;
    assign paused     = 1'b0;
`endif

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            phase_q <= P_IDLE;
            presc_q <= '0;
            rem_q   <= '0;
            to_q    <= 1'b0;
            wc_q    <= 1'b0;
            rc_q    <= 1'b0;
            sc_q    <= 1'b0;
        end else begin
            phase_q <= phase_d;
            presc_q <= presc_d;
            rem_q   <= rem_d;
            to_q    <= to_d;
            wc_q    <= wc_d;
            rc_q    <= rc_d;
            sc_q    <= sc_d;
        end
    end

    always_comb begin
        phase_d = phase_q;
        presc_d = presc_q;
        rem_d   = rem_q;
        to_d    = to_q;
        wc_d    = wc_q;
        rc_d    = rc_q;
        sc_d    = sc_q;
        done    = 1'b0;
        if (req != phase_q) begin
            phase_d = req;
            rem_d   = dur_of(req);
            presc_d = '0;
            to_d    = 1'b0;
            wc_d    = 1'b0;
            rc_d    = 1'b0;
            sc_d    = 1'b0;
        end else if (phase_q != P_IDLE) begin
            if (!paused) begin
                if (presc_q == PW'(CLK_DIV - 1)) begin
                    presc_d = '0;
                    if (rem_q != '0) rem_d = rem_q - CNT_W'(1);
                end else begin
                    presc_d = presc_q + PW'(1);
                end
            end
            // Flag rises together with the counter reaching zero, then holds.
            done = (rem_d == '0);
            case (phase_q)
                P_FILL, P_HEAT: to_d = to_q | done;
                P_WASH:         wc_d = wc_q | done;
                P_RINSE:        rc_d = rc_q | done;
                P_SPIN:         sc_d = sc_q | done;
                default:        ;
            endcase
        end
    end

    always_comb begin
        bus.phase               = phase_q;
        bus.remaining_Time      = rem_q;
        bus.sig_Time_Out        = to_q;
        bus.sig_Wash_Completed  = wc_q;
        bus.sig_Rinse_Completed = rc_q;
        bus.sig_Spin_Completed  = sc_q;
    end
endmodule

// File: tb/tb_phase_timer.sv
// tb/tb_phase_timer.sv - randomized model-checked bench for phase_timer
module tb_phase_timer;
    localparam int CLK_DIV = 4;
    localparam int CNT_W   = 16;

    logic clock   = 1'b0;
    logic reset_n = 1'b0;
    int   n_vec   = 0;
    int   n_err   = 0;
    bit   cmp_en  = 1'b0;

    int m_phase = 0;
    int m_act   = 0;
    int m_edges = 0;

    phase_timer_if #(.CNT_W(CNT_W)) bus();

    phase_timer dut (
        .clock   (clock),
        .reset_n (reset_n),
        .bus     (bus)
    );

    always #5 clock = ~clock;

    function automatic int dur(input int p);
        case (p)
            1: return 20;
            2: return 30;
            3: return 12;
            4: return 8;
            5: return 6;
            default: return 0;
        endcase
    endfunction

    function automatic int req_phase();
        if (bus.spin_Operation)            return 5;
        if (bus.rinse_Operation)           return 4;
        if (bus.wash_Operation)            return 3;
        if (bus.heat_Water_Operation)      return 2;
        if (bus.fill_Water_Operation)      return 1;
        return 0;
    endfunction

    function automatic int exp_rem();
        int t;
        if (m_phase == 0) return 0;
        t = m_act / CLK_DIV;
        return (t >= dur(m_phase)) ? 0 : dur(m_phase) - t;
    endfunction

    function automatic int exp_flag(input int which);
        bit expired;
        expired = (m_phase != 0) && (m_edges >= 1) && (exp_rem() == 0);
        case (which)
            0: return int'(expired && (m_phase == 1 || m_phase == 2));
            default: return int'(expired && (m_phase == which + 2));
        endcase
    endfunction

    // Reference: remaining time is the phase duration minus elapsed unpaused cycles in ticks.
    always @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            m_phase = 0;
            m_act   = 0;
            m_edges = 0;
        end else begin
            int r;
            bit pz;
            r  = req_phase();
            pz = 1'b0;
`ifdef PAUSE_ON_LID_EN
            pz = (m_phase >= 3) && !bus.sig_Lid_Closed;
`endif
            if (r != m_phase) begin
                m_phase = r;
                m_act   = 0;
                m_edges = 0;
            end else if (m_phase != 0) begin
                m_edges = m_edges + 1;
                if (!pz && m_act < 1000000) m_act = m_act + 1;
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec = n_vec + 1;
        if (act !== exp) begin
            n_err = n_err + 1;
            $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
        end
    endtask

    always @(negedge clock) begin
        if (cmp_en) begin
            chk("phase", 32'(bus.phase), m_phase);
            chk("remaining_Time", 32'(bus.remaining_Time), exp_rem());
            chk("sig_Time_Out", 32'(bus.sig_Time_Out), exp_flag(0));
            chk("sig_Wash_Completed", 32'(bus.sig_Wash_Completed), exp_flag(1));
            chk("sig_Rinse_Completed", 32'(bus.sig_Rinse_Completed), exp_flag(2));
            chk("sig_Spin_Completed", 32'(bus.sig_Spin_Completed), exp_flag(3));
        end
    end

    task automatic step(input int n);
        repeat (n) @(posedge clock);
        #1;
    endtask

    task automatic set_ops(input logic [4:0] v);
        bus.fill_Water_Operation = v[0];
        bus.heat_Water_Operation = v[1];
        bus.wash_Operation       = v[2];
        bus.rinse_Operation      = v[3];
        bus.spin_Operation       = v[4];
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_phase"}, 32'(bus.phase), 0);
        chk({tag, "_rem"}, 32'(bus.remaining_Time), 0);
        chk({tag, "_flags"}, 32'({bus.sig_Time_Out, bus.sig_Wash_Completed,
                                  bus.sig_Rinse_Completed, bus.sig_Spin_Completed}), 0);
    endtask

`ifdef PAUSE_ON_LID_EN
    localparam int SPIN_DONE = 34;
`else
    localparam int SPIN_DONE = 24;
`endif

    initial begin
        set_ops(5'b0);
        bus.sig_Lid_Closed = 1'b1;
        step(2);
        chk_all_zero("reset");
        reset_n = 1'b1;
        cmp_en  = 1'b1;
        step(1);

        // Wash from idle: 12 ticks of 4 cycles each.
        set_ops(5'b00100);
        step(1);
        chk("wash_entry_phase", 32'(bus.phase), 3);
        chk("wash_entry_rem", 32'(bus.remaining_Time), 12);
        step(47);
        chk("wash_47_rem", 32'(bus.remaining_Time), 1);
        chk("wash_47_flag", 32'(bus.sig_Wash_Completed), 0);
        step(1);
        chk("wash_48_rem", 32'(bus.remaining_Time), 0);
        chk("wash_48_flag", 32'(bus.sig_Wash_Completed), 1);
        set_ops(5'b0);
        step(1);
        chk_all_zero("wash_drop");

        // Fill timeout held, then dropped.
        set_ops(5'b00001);
        step(1);
        step(79);
        chk("fill_79_rem", 32'(bus.remaining_Time), 1);
        chk("fill_79_to", 32'(bus.sig_Time_Out), 0);
        step(1);
        chk("fill_80_to", 32'(bus.sig_Time_Out), 1);
        step(5);
        chk("fill_hold_to", 32'(bus.sig_Time_Out), 1);
        set_ops(5'b0);
        step(1);
        chk_all_zero("fill_drop");

        // Wash then direct move to rinse.
        set_ops(5'b00100);
        step(21);
        set_ops(5'b01000);
        step(1);
        chk("rinse_entry_rem", 32'(bus.remaining_Time), 8);
        chk("rinse_entry_phase", 32'(bus.phase), 4);
        chk("rinse_entry_wflag", 32'(bus.sig_Wash_Completed), 0);
        step(31);
        chk("rinse_31_flag", 32'(bus.sig_Rinse_Completed), 0);
        step(1);
        chk("rinse_32_flag", 32'(bus.sig_Rinse_Completed), 1);
        set_ops(5'b0);
        step(1);

        // Priority: spin beats wash.
        set_ops(5'b10100);
        step(1);
        chk("prio_phase", 32'(bus.phase), 5);
        chk("prio_rem", 32'(bus.remaining_Time), 6);
        set_ops(5'b0);
        step(1);

        // Spin with lid open for 10 clocks mid-phase.
        set_ops(5'b10000);
        step(1);
        step(5);
        bus.sig_Lid_Closed = 1'b0;
        step(10);
        bus.sig_Lid_Closed = 1'b1;
        step(SPIN_DONE - 16);
        chk("spin_before_flag", 32'(bus.sig_Spin_Completed), 0);
        step(1);
        chk("spin_done_flag", 32'(bus.sig_Spin_Completed), 1);
        set_ops(5'b0);
        step(1);

        // Asynchronous reset mid-wash takes effect before the next edge.
        set_ops(5'b00100);
        step(11);
        #2 reset_n = 1'b0;
        #1;
        chk_all_zero("async_reset");
        set_ops(5'b0);
        step(2);
        reset_n = 1'b1;
        step(1);

        // Randomized phase sequences with occasional lid openings and resets.
        for (int i = 0; i < 4000; i++) begin
            if ($urandom_range(0, 47) == 0) begin
                case ($urandom_range(0, 7))
                    0:       set_ops(5'b0);
                    1:       set_ops(5'b00001);
                    2:       set_ops(5'b00010);
                    3:       set_ops(5'b00100);
                    4:       set_ops(5'b01000);
                    5:       set_ops(5'b10000);
                    default: set_ops(5'($urandom_range(0, 31)));
                endcase
            end
            if ($urandom_range(0, 15) == 0) bus.sig_Lid_Closed = ~bus.sig_Lid_Closed;
            if ($urandom_range(0, 999) == 0) begin
                #2 reset_n = 1'b0;
                #1 chk_all_zero("rand_reset");
                step(1);
                reset_n = 1'b1;
            end
            step(1);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
